// File: rtl/ddr3_fb_reader.sv
// ddr3_fb_reader: two-slot line cache filled by MIG read bursts for an LCD controller.
// Define DDR3_FB_STATS_EN to build the saturating underrun counter.
module ddr3_fb_reader #(
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned PIX_W     = 6,
    parameter int unsigned X_W       = 9,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned X_LAST    = 319,
    parameter logic [29:0] BASE_ADDR = 30'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mig_ready_i,
    output logic             mig_cmd_en,
    output logic [2:0]       mig_cmd_instr,
    output logic [5:0]       mig_cmd_bl,
    output logic [29:0]      mig_cmd_byte_addr,
    input  logic             mig_cmd_full,
    output logic             mig_rd_en,
    input  logic [31:0]      mig_rd_data,
    input  logic             mig_rd_empty,
    input  logic             mig_rd_error,
    output logic             mig_wr_en,
    output logic [3:0]       mig_wr_mask,
    output logic [31:0]      mig_wr_data,
    input  logic [X_W-1:0]   x_i,
    input  logic [Y_W-1:0]   y_i,
    input  logic             in_hsync_i,
    input  logic             in_vsync_i,
    input  logic             pop_i,
    output logic [PIX_W-1:0] r_o,
    output logic [PIX_W-1:0] g_o,
    output logic [PIX_W-1:0] b_o,
    output logic             ack_o,
    output logic             underrun_o,
    output logic             err_o,
    output logic [15:0]      underrun_cnt_o
);
    localparam int unsigned EW = $clog2(BURST_LEN);
    localparam int unsigned CW = 3 * PIX_W;

    typedef enum logic [2:0] {
        FLUSH, IDLE, WAIT_CMD, EMIT_CMD, WAIT_DATA
    } state_t;

    state_t          state_q, state_d;
    logic [X_W-1:0]  tx_q;
    logic [Y_W-1:0]  ty_q;
    logic            tslot_q;
    logic [EW-1:0]   wcnt_q;
    logic            zdone_q;
    logic            err_q;
    logic [1:0]      valid_q, valid_d;
    logic [CW-1:0]   pix_q;
    logic            ack_q;
    logic            und_q;
    logic [CW-1:0]   mem_q [2*BURST_LEN];

    logic [EW-1:0]   ent;
    logic            slot;
    logic [31:0]     x_nxt;
    logic            trig, hs_fetch, ln_fetch, fetch;
    logic            word_ok, last_word, fill_done;
    logic [Y_W+X_W+1:0] off;
    logic            unused_rd;

    assign ent       = x_i[EW-1:0];
    assign slot      = x_i[EW];
    assign x_nxt     = 32'(x_i) + 32'(BURST_LEN);
    assign trig      = mig_ready_i & pop_i & ~in_vsync_i & (ent == '0);
    assign hs_fetch  = trig & in_hsync_i & ~zdone_q;
    assign ln_fetch  = trig & ~in_hsync_i & (x_nxt <= 32'(X_LAST));
    assign fetch     = hs_fetch | ln_fetch;
    assign word_ok   = (state_q == WAIT_DATA) & ~mig_rd_empty & ~mig_rd_error;
    assign last_word = (wcnt_q == EW'(BURST_LEN - 1));
    assign fill_done = word_ok & last_word;

    assign off               = {ty_q, tx_q, 2'b00};
    assign mig_cmd_byte_addr = BASE_ADDR + 30'(off);
    assign mig_cmd_instr     = 3'b001;
    assign mig_cmd_bl        = 6'(BURST_LEN - 1);
    assign mig_wr_en         = 1'b0;
    assign mig_wr_mask       = 4'h0;
    assign mig_wr_data       = 32'h0;
    assign unused_rd         = ^mig_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FLUSH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FLUSH:     if (mig_rd_empty) state_d = IDLE;
            IDLE:      if (fetch) state_d = WAIT_CMD;
            WAIT_CMD:  if (!mig_cmd_full) state_d = EMIT_CMD;
            EMIT_CMD:  state_d = WAIT_DATA;
            WAIT_DATA: if (fill_done) state_d = IDLE;
            default:   state_d = FLUSH;
        endcase
        if (mig_rd_error) state_d = FLUSH;
    end

    // FLUSH drains stale read data, so the pop is held off while in reset.
    always_comb begin
        mig_cmd_en = 1'b0;
        mig_rd_en  = 1'b0;
        case (state_q)
            EMIT_CMD:         mig_cmd_en = 1'b1;
            FLUSH, WAIT_DATA: mig_rd_en  = rst_n & ~mig_rd_empty;
            default:          ;
        endcase
    end

    // A completing fill wins over a pop clearing the same slot.
    always_comb begin
        valid_d = valid_q;
        if (pop_i && ent == EW'(BURST_LEN - 1)) valid_d[slot] = 1'b0;
        if (fill_done) valid_d[tslot_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q    <= '0;
            ty_q    <= '0;
            tslot_q <= 1'b0;
            wcnt_q  <= '0;
            zdone_q <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 2'b00;
            pix_q   <= '0;
            ack_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && fetch) begin
                ty_q    <= y_i;
                tx_q    <= hs_fetch ? '0 : x_nxt[X_W-1:0];
                tslot_q <= hs_fetch ? 1'b0 : ~slot;
                zdone_q <= hs_fetch;
            end
            if (state_q == EMIT_CMD) wcnt_q <= '0;
            else if (word_ok)        wcnt_q <= wcnt_q + EW'(1);
            if (mig_rd_error) err_q <= 1'b1;
            valid_q <= valid_d;
            ack_q   <= pop_i;
            und_q   <= pop_i & ~valid_q[slot];
            if (pop_i) pix_q <= valid_q[slot] ? mem_q[{slot, ent}] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (word_ok)
            mem_q[{tslot_q, wcnt_q}] <= {mig_rd_data[23 -: PIX_W],
                                         mig_rd_data[15 -: PIX_W],
                                         mig_rd_data[7 -: PIX_W]};
    end

    assign r_o        = pix_q[CW-1 -: PIX_W];
    assign g_o        = pix_q[2*PIX_W-1 -: PIX_W];
    assign b_o        = pix_q[PIX_W-1:0];
    assign ack_o      = ack_q;
    assign underrun_o = und_q;
    assign err_o      = err_q;

`ifdef DDR3_FB_STATS_EN
    logic [15:0] ucnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ucnt_q <= '0;
        else if (pop_i && !valid_q[slot] && ucnt_q != 16'hFFFF)
            ucnt_q <= ucnt_q + 16'd1;
    end
    assign underrun_cnt_o = ucnt_q;
`else
    assign underrun_cnt_o = 16'h0;
`endif

endmodule

// File: doc/ddr3_fb_reader.md
DDR3_FB_READER -- requirements
Module: ddr3_fb_reader

Interface
REQ-001 SHALL have parameters, one per line:
- BURST_LEN, 8, words per MIG read burst, power of 2 in 2..64.
- PIX_W, 6, bits per colour channel, 1..8.
- X_W, 9, x coordinate width.
- Y_W, 7, y coordinate width.
- X_LAST, 319, last valid x of a line.
- BASE_ADDR, 30'h0, frame base byte address.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, sole clock; also drives mig_cmd_clk, mig_wr_clk and mig_rd_clk.
- rst_n, in, 1, asynchronous active-low reset.
- mig_ready_i, in, 1, MIG calibration done.
- mig_cmd_en/instr/bl/byte_addr, out, 1/3/6/30, read command.
- mig_cmd_full, in, 1, command FIFO full.
- mig_rd_en, out, 1, read FIFO pop.
- mig_rd_data, in, 32, read data.
- mig_rd_empty, in, 1, read FIFO empty.
- mig_rd_error, in, 1, read FIFO error.
- mig_wr_en/mask/data, out, 1/4/32, tied to 0.
- x_i, in, X_W, LCDC pixel x.
- y_i, in, Y_W, LCDC line.
- in_hsync_i, in, 1, horizontal blanking.
- in_vsync_i, in, 1, vertical blanking.
- pop_i, in, 1, pixel request.
- r_o/g_o/b_o, out, PIX_W, pixel.
- ack_o, out, 1, pixel valid.
- underrun_o, out, 1, pop hit an unfilled slot.
- err_o, out, 1, sticky MIG read error.
- underrun_cnt_o, out, 16, underrun counter.

Function
REQ-003 SHALL keep two cache slots of BURST_LEN entries each; slot = (x_i / BURST_LEN) mod 2; entry = x_i mod BURST_LEN.
REQ-004 SHALL keep a valid bit per slot. A slot becomes valid in the cycle its last word is written. It is cleared when a pop reads entry BURST_LEN-1 of that slot.
REQ-005 SHALL use FSM states FLUSH, IDLE, WAIT_CMD, EMIT_CMD, WAIT_DATA.
REQ-006 Trigger: in IDLE, mig_ready_i=1, pop_i=1, in_vsync_i=0, and x_i mod BURST_LEN = 0.
- If in_hsync_i=1 and the zero-chunk-done flag is 0: target x=0, line y_i, slot 0; set the flag.
- If in_hsync_i=0 and x_i+BURST_LEN <= X_LAST: target x=x_i+BURST_LEN, line y_i, the opposite slot; clear the flag.
- Any other case: no fetch.
- On a fetch: go to WAIT_CMD.
REQ-007 WAIT_CMD -> EMIT_CMD when mig_cmd_full=0; it stays in WAIT_CMD indefinitely otherwise.
REQ-008 EMIT_CMD lasts one cycle with mig_cmd_en=1, then goes to WAIT_DATA.
- mig_cmd_instr = 3'b001.
- mig_cmd_bl = BURST_LEN-1.
- mig_cmd_byte_addr = BASE_ADDR + {y, x, 2'b00}, truncated to 30 bits.
REQ-009 In WAIT_DATA, mig_rd_en = ~mig_rd_empty.
- Each accepted word writes r=[23:24-PIX_W], g=[15:16-PIX_W], b=[7:8-PIX_W] to the next entry.
- After BURST_LEN words: go to IDLE.
REQ-010 Triggers arriving outside IDLE SHALL be dropped, with no queueing.
REQ-011 mig_rd_error=1 in any state SHALL set err_o, abandon the current fill (slot stays invalid) and go to FLUSH.
REQ-012 In FLUSH, mig_rd_en = ~mig_rd_empty; go to IDLE on the first cycle mig_rd_empty=1.
REQ-013 Pop output SHALL be registered, 1-cycle latency: ack_o=1 in the cycle after every pop_i=1.
- Slot valid: r/g/b = cache entry.
- Slot invalid: r/g/b = 0 and underrun_o=1 for that cycle.
REQ-014 A fill write and a pop read to the same entry in the same cycle SHALL return the old contents.
REQ-015 A valid-set and a valid-clear on the same slot in the same cycle SHALL resolve as set.

Reset
REQ-016 rst_n=0 SHALL asynchronously force:
- FSM=FLUSH, both slots invalid, zero-chunk-done flag=0.
- r_o/g_o/b_o=0, ack_o=0, underrun_o=0, err_o=0, underrun_cnt_o=0.
- mig_cmd_en=0, mig_rd_en=0.
REQ-017 Reset mid-burst SHALL discard the fill; residual MIG read data SHALL be drained by FLUSH.
REQ-018 Cache memory contents SHALL NOT be reset.

Configuration
REQ-019 With DDR3_FB_STATS_EN defined, underrun_cnt_o SHALL increment on each underrun_o pulse and saturate at 16'hFFFF; without it, underrun_cnt_o SHALL be constant 0 and the counter SHALL not be synthesised.

Verification
REQ-020 The bench SHALL cover:
- Reset release with mig_rd_empty=1: FLUSH -> IDLE in 1 cycle; all outputs 0.
- hsync pop, y_i=5, BURST_LEN=8, then 8 words 0x00FCFCFC: one cmd at addr 0x2800; slot 0 valid; pop x=3 -> r=g=b=6'h3F, ack_o=1 next cycle.
- Pop at x=8, mig_cmd_full=1 for 10 cycles: mig_cmd_en asserted exactly once, after full drops, addr {y,9'd16,2'b00}.
- Pop of an unfilled slot: r/g/b=0, underrun_o=1; with DDR3_FB_STATS_EN, 3 such pops -> underrun_cnt_o=3.
- mig_rd_error after word 4: err_o=1 held; FSM drains via FLUSH; slot stays invalid.
- Pop at x=312 with X_LAST=319: no command issued.
